// File: rtl/sha2_pad.sv
// SHA-256 message padder: packs 32-bit words into 512-bit blocks and appends the 0x80 marker, zero fill and 64-bit length.
// Optional length cross-check is enabled by defining SHA2_PAD_LEN_CHK_EN.
module sha2_pad (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_p,
    input  logic [63:0]  msg_len,
    input  logic         msg_vld,
    input  logic [31:0]  msg_dat,
    input  logic [3:0]   msg_be,
    input  logic         msg_lst,
    output logic         msg_rdy,
    output logic         blk_vld,
    output logic [511:0] blk_dat,
    output logic         blk_first,
    output logic         blk_last,
    input  logic         blk_rdy,
    output logic         busy,
    output logic         len_err
);

    typedef enum logic [1:0] {IDLE, FILL, PAD, OUT} state_t;

    state_t      state;
    logic [31:0] blk_buf [16];
    logic [4:0]  wptr;
    logic        pend80;
    logic        first_f;
    logic        last_f;
    logic        lst_seen;
    logic [63:0] len_q;
    logic        accept;
    logic [31:0] word_in;
    logic [4:0]  pad_ptr;

    assign msg_rdy   = (state == FILL);
    assign accept    = msg_rdy && msg_vld;
    assign busy      = (state != IDLE);
    assign blk_vld   = (state == OUT);
    assign blk_first = blk_vld && first_f;
    assign blk_last  = blk_vld && last_f;
    assign pad_ptr   = wptr + {4'b0, pend80};

    // Disabled bytes are zeroed; on a partial last word the first disabled byte carries the marker.
    always_comb begin
        word_in = msg_dat & {{8{msg_be[3]}}, {8{msg_be[2]}}, {8{msg_be[1]}}, {8{msg_be[0]}}};
        if (msg_lst) begin
            if (!msg_be[3])      word_in[31:24] = 8'h80;
            else if (!msg_be[2]) word_in[23:16] = 8'h80;
            else if (!msg_be[1]) word_in[15:8]  = 8'h80;
            else if (!msg_be[0]) word_in[7:0]   = 8'h80;
        end
    end

    always_comb begin
        blk_dat = '0;
        for (int i = 0; i < 16; i++) begin
            blk_dat[511 - 32*i -: 32] = blk_buf[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            wptr     <= '0;
            pend80   <= 1'b0;
            first_f  <= 1'b0;
            last_f   <= 1'b0;
            lst_seen <= 1'b0;
            len_q    <= '0;
            for (int i = 0; i < 16; i++) blk_buf[i] <= '0;
        end else if (start_p) begin
            // A zero-length message has no words, so it jumps straight to padding.
            for (int i = 0; i < 16; i++) blk_buf[i] <= '0;
            wptr     <= '0;
            first_f  <= 1'b1;
            last_f   <= 1'b0;
            len_q    <= msg_len;
            pend80   <= (msg_len == 64'd0);
            lst_seen <= (msg_len == 64'd0);
            state    <= (msg_len == 64'd0) ? PAD : FILL;
        end else begin
            case (state)
                IDLE: ;
                FILL: begin
                    if (accept) begin
                        blk_buf[wptr[3:0]] <= word_in;
                        wptr <= wptr + 5'd1;
                        if (msg_lst) begin
                            lst_seen <= 1'b1;
                            pend80   <= (msg_be == 4'hF);
                        end
                        if (wptr == 5'd15)  state <= OUT;
                        else if (msg_lst)   state <= PAD;
                    end
                end
                PAD: begin
                    for (int i = 0; i < 16; i++) begin
                        if (pend80 && (5'(i) == wptr)) blk_buf[i] <= 32'h8000_0000;
                        else if (5'(i) >= pad_ptr)     blk_buf[i] <= 32'h0;
                    end
                    // The length only fits if two words remain after the marker.
                    if (pad_ptr <= 5'd14) begin
                        blk_buf[14] <= len_q[63:32];
                        blk_buf[15] <= len_q[31:0];
                        last_f      <= 1'b1;
                    end
                    wptr   <= pad_ptr;
                    pend80 <= 1'b0;
                    state  <= OUT;
                end
                OUT: begin
                    if (blk_rdy) begin
                        first_f <= 1'b0;
                        wptr    <= '0;
                        if (last_f)        state <= IDLE;
                        else if (lst_seen) state <= PAD;
                        else               state <= FILL;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SHA2_PAD_LEN_CHK_EN
    logic [63:0] bit_cnt;
    logic [63:0] bit_add;
    logic [3:0]  byte_cnt;

    always_comb begin
        byte_cnt = {3'b0, msg_be[3]} + {3'b0, msg_be[2]} + {3'b0, msg_be[1]} + {3'b0, msg_be[0]};
        bit_add  = {57'b0, byte_cnt, 3'b0};
    end

    // Counts delivered bits and flags a mismatch against the declared length at the last word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= '0;
            len_err <= 1'b0;
        end else if (start_p) begin
            bit_cnt <= '0;
            len_err <= 1'b0;
        end else if (accept) begin
            bit_cnt <= bit_cnt + bit_add;
            if (msg_lst && ((bit_cnt + bit_add) != len_q)) len_err <= 1'b1;
        end
    end
`else
    assign len_err = 1'b0;
`endif

endmodule

// File: tb/tb_sha2_pad.sv
// Directed self-checking bench for sha2_pad; expected blocks are hand-built from the padding rules.
module tb_sha2_pad;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start_p = 1'b0;
    logic [63:0]  msg_len = '0;
    logic         msg_vld = 1'b0;
    logic [31:0]  msg_dat = '0;
    logic [3:0]   msg_be = '0;
    logic         msg_lst = 1'b0;
    logic         msg_rdy;
    logic         blk_vld;
    logic [511:0] blk_dat;
    logic         blk_first;
    logic         blk_last;
    logic         blk_rdy = 1'b0;
    logic         busy;
    logic         len_err;

    int           errors = 0;
    int           checks = 0;
    logic [511:0] exp_blk;

`ifdef SHA2_PAD_LEN_CHK_EN
    localparam logic LEN_CHK = 1'b1;
`else
    localparam logic LEN_CHK = 1'b0;
`endif

    sha2_pad dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_p   (start_p),
        .msg_len   (msg_len),
        .msg_vld   (msg_vld),
        .msg_dat   (msg_dat),
        .msg_be    (msg_be),
        .msg_lst   (msg_lst),
        .msg_rdy   (msg_rdy),
        .blk_vld   (blk_vld),
        .blk_dat   (blk_dat),
        .blk_first (blk_first),
        .blk_last  (blk_last),
        .blk_rdy   (blk_rdy),
        .busy      (busy),
        .len_err   (len_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkBit(input string tag, input logic obs, input logic exp);
        checkOutput(tag, {511'b0, obs}, {511'b0, exp});
    endtask

    function automatic void setWord(input int idx, input logic [31:0] v);
        exp_blk[511 - 32*idx -: 32] = v;
    endfunction

    task automatic startMsg(input logic [63:0] len);
        start_p = 1'b1;
        msg_len = len;
        tick();
        start_p = 1'b0;
    endtask

    task automatic applyStimulus(input logic [31:0] dat, input logic [3:0] be, input logic lst);
        int n = 0;
        msg_vld = 1'b1;
        msg_dat = dat;
        msg_be  = be;
        msg_lst = lst;
        while (msg_rdy !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        checkBit("msg_rdy_wait", msg_rdy, 1'b1);
        tick();
        msg_vld = 1'b0;
        msg_lst = 1'b0;
        msg_be  = '0;
        msg_dat = '0;
    endtask

    task automatic waitBlk(input string tag);
        int n = 0;
        while (blk_vld !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        checkBit({tag, "_vld"}, blk_vld, 1'b1);
    endtask

    task automatic takeBlk(input string tag, input logic f, input logic l);
        checkOutput({tag, "_dat"}, blk_dat, exp_blk);
        checkBit({tag, "_first"}, blk_first, f);
        checkBit({tag, "_last"}, blk_last, l);
        blk_rdy = 1'b1;
        tick();
        blk_rdy = 1'b0;
    endtask

    initial begin
        // Reset values
        tick();
        tick();
        checkBit("rst_msg_rdy", msg_rdy, 1'b0);
        checkBit("rst_blk_vld", blk_vld, 1'b0);
        checkBit("rst_blk_first", blk_first, 1'b0);
        checkBit("rst_blk_last", blk_last, 1'b0);
        checkBit("rst_busy", busy, 1'b0);
        checkBit("rst_len_err", len_err, 1'b0);
        checkOutput("rst_blk_dat", blk_dat, 512'd0);
        rst_n = 1'b1;
        tick();

        // "abc": 3 bytes, marker inside the last word
        $display("[TB] abc message");
        startMsg(64'h18);
        checkBit("abc_busy", busy, 1'b1);
        applyStimulus(32'h6162_6300, 4'b1110, 1'b1);
        checkBit("abc_vld_n1", blk_vld, 1'b0);
        checkBit("abc_rdy_pad", msg_rdy, 1'b0);
        tick();
        checkBit("abc_vld_n2", blk_vld, 1'b1);
        exp_blk = '0;
        setWord(0, 32'h6162_6380);
        setWord(15, 32'h0000_0018);
        takeBlk("abc", 1'b1, 1'b1);
        checkBit("abc_idle", busy, 1'b0);

        // Empty message
        $display("[TB] empty message");
        startMsg(64'h0);
        checkBit("empty_rdy", msg_rdy, 1'b0);
        tick();
        checkBit("empty_rdy2", msg_rdy, 1'b0);
        checkBit("empty_vld", blk_vld, 1'b1);
        exp_blk = '0;
        setWord(0, 32'h8000_0000);
        takeBlk("empty", 1'b1, 1'b1);

        // 14 full words: length spills into a second block
        $display("[TB] 14-word message");
        startMsg(64'h1C0);
        for (int i = 0; i < 14; i++) applyStimulus(32'hA000_0000 + 32'(i), 4'hF, i == 13);
        waitBlk("w14a");
        exp_blk = '0;
        for (int i = 0; i < 14; i++) setWord(i, 32'hA000_0000 + 32'(i));
        setWord(14, 32'h8000_0000);
        takeBlk("w14a", 1'b1, 1'b0);
        waitBlk("w14b");
        exp_blk = '0;
        setWord(15, 32'h0000_01C0);
        takeBlk("w14b", 1'b0, 1'b1);

        // 16 full words with back-pressure on both blocks
        $display("[TB] 16-word message with stalls");
        startMsg(64'h200);
        for (int i = 0; i < 16; i++) applyStimulus(32'hB000_0000 + 32'(i), 4'hF, i == 15);
        checkBit("w16_vld_n1", blk_vld, 1'b1);
        exp_blk = '0;
        for (int i = 0; i < 16; i++) setWord(i, 32'hB000_0000 + 32'(i));
        for (int i = 0; i < 5; i++) begin
            checkOutput("w16a_stall_dat", blk_dat, exp_blk);
            checkBit("w16a_stall_rdy", msg_rdy, 1'b0);
            tick();
        end
        takeBlk("w16a", 1'b1, 1'b0);
        waitBlk("w16b");
        exp_blk = '0;
        setWord(0, 32'h8000_0000);
        setWord(15, 32'h0000_0200);
        for (int i = 0; i < 5; i++) begin
            checkOutput("w16b_stall_dat", blk_dat, exp_blk);
            checkBit("w16b_stall_last", blk_last, 1'b1);
            tick();
        end
        takeBlk("w16b", 1'b0, 1'b1);

        // Abort after 5 of 10 words, then a fresh 3-byte message
        $display("[TB] abort and restart");
        startMsg(64'h140);
        for (int i = 0; i < 5; i++) applyStimulus(32'hC000_0000 + 32'(i), 4'hF, 1'b0);
        checkBit("abort_vld", blk_vld, 1'b0);
        startMsg(64'h18);
        applyStimulus(32'h6162_6300, 4'b1110, 1'b1);
        waitBlk("abort");
        exp_blk = '0;
        setWord(0, 32'h6162_6380);
        setWord(15, 32'h0000_0018);
        takeBlk("abort", 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            checkBit("abort_no_extra", blk_vld, 1'b0);
            tick();
        end

        // Marker positions for be=1100 and be=1000, with garbage in disabled bytes
        $display("[TB] partial last words");
        startMsg(64'h30);
        applyStimulus(32'h6162_6364, 4'hF, 1'b0);
        applyStimulus(32'h6566_FFFF, 4'b1100, 1'b1);
        waitBlk("be1100");
        exp_blk = '0;
        setWord(0, 32'h6162_6364);
        setWord(1, 32'h6566_8000);
        setWord(15, 32'h0000_0030);
        takeBlk("be1100", 1'b1, 1'b1);
        startMsg(64'h28);
        applyStimulus(32'h6162_6364, 4'hF, 1'b0);
        applyStimulus(32'h65AA_BBCC, 4'b1000, 1'b1);
        waitBlk("be1000");
        exp_blk = '0;
        setWord(0, 32'h6162_6364);
        setWord(1, 32'h6580_0000);
        setWord(15, 32'h0000_0028);
        takeBlk("be1000", 1'b1, 1'b1);

        // Asynchronous reset mid-message
        $display("[TB] reset mid-message");
        startMsg(64'h100);
        for (int i = 0; i < 3; i++) applyStimulus(32'hD000_0000 + 32'(i), 4'hF, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checkBit("arst_busy", busy, 1'b0);
        checkBit("arst_rdy", msg_rdy, 1'b0);
        checkBit("arst_vld", blk_vld, 1'b0);
        checkOutput("arst_dat", blk_dat, 512'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Length mismatch: declared 0x20, delivered 24 bits
        $display("[TB] length check");
        startMsg(64'h20);
        applyStimulus(32'h6162_6300, 4'b1110, 1'b1);
        checkBit("lenerr_set", len_err, LEN_CHK);
        waitBlk("lenerr");
        exp_blk = '0;
        setWord(0, 32'h6162_6380);
        setWord(15, 32'h0000_0020);
        takeBlk("lenerr", 1'b1, 1'b1);
        checkBit("lenerr_sticky", len_err, LEN_CHK);
        startMsg(64'h18);
        checkBit("lenerr_clear", len_err, 1'b0);
        applyStimulus(32'h6162_6300, 4'b1110, 1'b1);
        checkBit("lenerr_match", len_err, 1'b0);
        waitBlk("lenok");
        exp_blk = '0;
        setWord(0, 32'h6162_6380);
        setWord(15, 32'h0000_0018);
        takeBlk("lenok", 1'b1, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
